// File: rtl/gpio_bank_ctrl_pkg.sv
// Shared types for the GPIO bank controller.
//   op_e        : host command opcodes
//   state_e     : command FSM states
//   NUM_BANK    : number of 4-pin banks
//   bank_idx_t  : bank selector type
package gpio_bank_ctrl_pkg;

  localparam int NUM_BANK = 4;
  localparam int BANK_W   = 2;

  typedef logic [BANK_W-1:0] bank_idx_t;

  typedef enum logic [1:0] {
    OP_WR_DIR  = 2'd0,
    OP_WR_OUT  = 2'd1,
    OP_RD_IN   = 2'd2,
    OP_CLR_IRQ = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TURN = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/gpio_bank_ctrl_pin_sync.sv
// Input conditioning for one GPIO bank: a SYNC_STG-deep synchronizer per
// pin, a one-cycle history flop, and a rising-edge qualifier.
//   clk_i, rst_n_i : clock, synchronous active-low reset
//   pad_i          : raw pad levels of the bank
//   dir_i          : direction bits (1 = output); outputs never flag edges
//   armed_i        : edge capture enable
//   sync_o         : synchronized pad levels
//   rise_o         : qualified rising edges, one cycle wide
module gpio_pin_sync
  import gpio_bank_ctrl_pkg::*;
#(
  parameter int DATA_W   = 4,
  parameter int SYNC_STG = 2
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [DATA_W-1:0] pad_i,
  input  logic [DATA_W-1:0] dir_i,
  input  logic              armed_i,
  output logic [DATA_W-1:0] sync_o,
  output logic [DATA_W-1:0] rise_o
);

  logic [DATA_W-1:0] sync_reg [SYNC_STG];
  logic [DATA_W-1:0] prev_reg;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      for (int k = 0; k < SYNC_STG; k++) begin
        sync_reg[k] <= '0;
      end
      prev_reg <= '0;
    end else begin
      sync_reg[0] <= pad_i;
      for (int k = 1; k < SYNC_STG; k++) begin
        sync_reg[k] <= sync_reg[k-1];
      end
      prev_reg <= sync_reg[SYNC_STG-1];
    end
  end

  assign sync_o = sync_reg[SYNC_STG-1];
  assign rise_o = sync_o & ~prev_reg & ~dir_i & {DATA_W{armed_i}};

endmodule

// File: rtl/gpio_bank_ctrl.sv
// Command-driven controller for four 4-bit bidirectional GPIO banks.
// Owns direction/output registers, drives the pads, collects rising edges
// on input pins into sticky status, and answers host commands with a
// one-cycle response pulse.
//   clk_i, rst_n_i          : clock, synchronous active-low reset
//   cmd_valid_i/cmd_ready_o : command handshake (ready only in IDLE)
//   cmd_op_i                : 0=WR_DIR 1=WR_OUT 2=RD_IN 3=CLR_IRQ
//   cmd_bank_i, cmd_data_i  : target bank, write data / W1C mask
//   rsp_valid_o, rsp_data_o : response pulse and data (data holds after)
//   irq_o                   : registered OR of all status bits
//   b3..b0_data_io          : bank pads
module gpio_bank_ctrl
  import gpio_bank_ctrl_pkg::*;
#(
  parameter int DATA_W   = 4,
  parameter int TURN_CYC = 2,
  parameter int SYNC_STG = 2
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [1:0]        cmd_op_i,
  input  bank_idx_t         cmd_bank_i,
  input  logic [DATA_W-1:0] cmd_data_i,
  output logic              rsp_valid_o,
  output logic [DATA_W-1:0] rsp_data_o,
  output logic              irq_o,
  inout  wire  [DATA_W-1:0] b3_data_io,
  inout  wire  [DATA_W-1:0] b2_data_io,
  inout  wire  [DATA_W-1:0] b1_data_io,
  inout  wire  [DATA_W-1:0] b0_data_io
);

  state_e            state_reg, state_next;
  logic [DATA_W-1:0] dir_reg    [NUM_BANK];
  logic [DATA_W-1:0] out_reg    [NUM_BANK];
  logic [DATA_W-1:0] status_reg [NUM_BANK];
  logic [DATA_W-1:0] oe         [NUM_BANK];
  logic [DATA_W-1:0] pad_in     [NUM_BANK];
  logic [DATA_W-1:0] sync_val   [NUM_BANK];
  logic [DATA_W-1:0] rise       [NUM_BANK];
  logic [DATA_W-1:0] clr_mask   [NUM_BANK];
  logic [3:0]        turn_cnt_reg;
  bank_idx_t         turn_bank_reg;
  logic [DATA_W-1:0] turn_data_reg;
  logic [DATA_W-1:0] rsp_data_reg;
  logic              irq_reg;
  logic [1:0]        arm_cnt_reg;
  logic              armed_reg;
  logic              status_any;
  logic              accept;
  logic [DATA_W-1:0] new_out_bits;
  op_e               cmd_op;

  assign cmd_op       = op_e'(cmd_op_i);
  assign cmd_ready_o  = (state_reg == ST_IDLE) && rst_n_i;
  assign accept       = cmd_valid_i && cmd_ready_o;
  assign new_out_bits = cmd_data_i & ~dir_reg[cmd_bank_i];
  assign rsp_valid_o  = (state_reg == ST_RESP);
  assign rsp_data_o   = rsp_data_reg;
  assign irq_o        = irq_reg;

  assign pad_in[0] = b0_data_io;
  assign pad_in[1] = b1_data_io;
  assign pad_in[2] = b2_data_io;
  assign pad_in[3] = b3_data_io;

  // Reset tri-states the pads combinationally, without waiting for an edge.
  for (genvar gi = 0; gi < NUM_BANK; gi++) begin : g_bank
    assign oe[gi]       = dir_reg[gi] & {DATA_W{rst_n_i}};
    assign clr_mask[gi] = (accept && cmd_op == OP_CLR_IRQ && cmd_bank_i == bank_idx_t'(gi))
                          ? cmd_data_i : '0;

    gpio_pin_sync #(
      .DATA_W   (DATA_W),
      .SYNC_STG (SYNC_STG)
    ) u_sync (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .pad_i   (pad_in[gi]),
      .dir_i   (dir_reg[gi]),
      .armed_i (armed_reg),
      .sync_o  (sync_val[gi]),
      .rise_o  (rise[gi])
    );
  end

  for (genvar gi = 0; gi < DATA_W; gi++) begin : g_pad
    assign b0_data_io[gi] = oe[0][gi] ? out_reg[0][gi] : 1'bz;
    assign b1_data_io[gi] = oe[1][gi] ? out_reg[1][gi] : 1'bz;
    assign b2_data_io[gi] = oe[2][gi] ? out_reg[2][gi] : 1'bz;
    assign b3_data_io[gi] = oe[3][gi] ? out_reg[3][gi] : 1'bz;
  end

  always_comb begin
    status_any = 1'b0;
    for (int b = 0; b < NUM_BANK; b++) begin
      status_any = status_any | (|status_reg[b]);
    end
  end

  // FSM: state register
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM: next state. Only a direction write that turns an input into an
  // output needs the turnaround wait.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          if (cmd_op == OP_WR_DIR && |new_out_bits) begin
            state_next = ST_TURN;
          end else begin
            state_next = ST_RESP;
          end
        end
      end
      ST_TURN: begin
        if (turn_cnt_reg == 4'd0) begin
          state_next = ST_RESP;
        end
      end
      ST_RESP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      for (int b = 0; b < NUM_BANK; b++) begin
        dir_reg[b]    <= '0;
        out_reg[b]    <= '0;
        status_reg[b] <= '0;
      end
      turn_cnt_reg  <= '0;
      turn_bank_reg <= '0;
      turn_data_reg <= '0;
      rsp_data_reg  <= '0;
      irq_reg       <= 1'b0;
      arm_cnt_reg   <= '0;
      armed_reg     <= 1'b0;
    end else begin
      // Arm one cycle after the synchronizer has filled, so a pin that was
      // already high at reset reaches the history flop before capture opens.
      if (!armed_reg) begin
        if (arm_cnt_reg == 2'(SYNC_STG)) begin
          armed_reg <= 1'b1;
        end else begin
          arm_cnt_reg <= arm_cnt_reg + 2'd1;
        end
      end

      irq_reg <= status_any;

      // A new edge on a bit being cleared keeps that bit set.
      for (int b = 0; b < NUM_BANK; b++) begin
        status_reg[b] <= (status_reg[b] & ~clr_mask[b]) | rise[b];
      end

      if (accept) begin
        case (cmd_op)
          OP_WR_DIR: begin
            if (|new_out_bits) begin
              // Releases take effect now; new outputs wait for turnaround.
              dir_reg[cmd_bank_i] <= dir_reg[cmd_bank_i] & cmd_data_i;
              turn_bank_reg       <= cmd_bank_i;
              turn_data_reg       <= cmd_data_i;
              turn_cnt_reg        <= 4'(TURN_CYC - 1);
            end else begin
              dir_reg[cmd_bank_i] <= cmd_data_i;
              rsp_data_reg        <= '0;
            end
          end
          OP_WR_OUT: begin
            out_reg[cmd_bank_i] <= cmd_data_i;
            rsp_data_reg        <= '0;
          end
          OP_RD_IN:   rsp_data_reg <= sync_val[cmd_bank_i];
          OP_CLR_IRQ: rsp_data_reg <= status_reg[cmd_bank_i];
          default:    rsp_data_reg <= rsp_data_reg;
        endcase
      end

      if (state_reg == ST_TURN) begin
        if (turn_cnt_reg == 4'd0) begin
          dir_reg[turn_bank_reg] <= turn_data_reg;
          rsp_data_reg           <= '0;
        end else begin
          turn_cnt_reg <= turn_cnt_reg - 4'd1;
        end
      end
    end
  end

endmodule

// File: doc/gpio_bank_ctrl.md
Name: gpio_bank_ctrl

Overview:
Command-driven controller for four 4-bit bidirectional GPIO banks (b3..b0). It owns the per-pin direction and output registers and drives the inout pins. It synchronizes pin inputs, detects rising edges into a sticky interrupt status, and serialises host commands through a valid/ready front end with a pulsed response. It inserts a configurable turnaround delay before any pin starts driving.

Parameters:
DATA_W, 4, pins per bank (fixed at 4 in this release)
TURN_CYC, 2, cycles a pin stays undriven between an input-to-output direction write and drive enable (1..15)
SYNC_STG, 2, input synchronizer depth (2 or 3)

Ports:
clk_i  in  1  clock; all state on rising edge
rst_n_i  in  1  synchronous active-low reset
cmd_valid_i  in  1  command valid
cmd_ready_o  out  1  controller can accept a command
cmd_op_i  in  2  0=WR_DIR, 1=WR_OUT, 2=RD_IN, 3=CLR_IRQ
cmd_bank_i  in  2  target bank 0..3
cmd_data_i  in  4  write data / W1C clear mask
rsp_valid_o  out  1  one-cycle response pulse
rsp_data_o  out  4  response data
irq_o  out  1  OR of all sticky edge-status bits
b3_data_io  inout  4  bank 3 pins
b2_data_io  inout  4  bank 2 pins
b1_data_io  inout  4  bank 1 pins
b0_data_io  inout  4  bank 0 pins

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-low (rst_n_i sampled on clk_i rising edge).
- Reset values: dir=0 (all input), out=0, oe=0 (all pins Z), status=0, sync/prev flops=0, FSM=IDLE, cmd_ready_o=0 during reset, rsp_valid_o=0, rsp_data_o=0, irq_o=0.
- Arming: a 2-bit counter blocks edge capture for SYNC_STG+1 cycles after reset release. Pins that are high at reset must not set status.
- Pin drive: bit i of bank b is driven with out[b][i] when oe[b][i]=1, else Z. oe = dir, except bits held off during turnaround.
- Input path: SYNC_STG-flop synchronizer per pin, then one prev flop. rise = sync & ~prev & ~dir & armed. Status |= rise every cycle.
- FSM states: IDLE, TURN, RESP. cmd_ready_o=1 only in IDLE (and not in reset). Accept = cmd_valid_i & cmd_ready_o in cycle T.
- WR_OUT: out[bank] <= data at the T edge. RESP in T+1, rsp_data_o=0.
- RD_IN: rsp_data_o <= sync value of the bank captured at the T edge; for output pins this reads back the synchronized pad. RESP in T+1.
- CLR_IRQ: status[bank] &= ~data at the T edge. rsp_data_o = status before the clear. An edge in the same cycle on the same bit wins (bit stays 1). RESP in T+1.
- WR_DIR, no bit changing 0->1: dir <= data at T. Released bits go Z from T+1. RESP in T+1.
- WR_DIR, some bit changing 0->1:
  - 1->0 bits release at T.
  - The new output bits stay oe=0 through TURN for TURN_CYC cycles (down-counter).
  - dir/oe for those bits apply on the last TURN edge.
  - RESP follows, so rsp_valid_o rises at T+1+TURN_CYC.
- RESP: rsp_valid_o=1 for exactly one cycle, then IDLE. There is no response backpressure. rsp_data_o holds its last value outside the pulse.
- Back-to-back: minimum command spacing is 2 cycles (accept, RESP). cmd_valid_i held high is re-accepted in the IDLE cycle after RESP.
- Reset mid-operation (TURN or RESP): everything returns to reset values next edge. The pending response is dropped and pins tri-state immediately.
- irq_o is registered: asserts the cycle after status goes nonzero, drops the cycle after the last bit clears.

Decomposition:
- Package gpio_bank_ctrl_pkg holds:
  - op enum (WR_DIR, WR_OUT, RD_IN, CLR_IRQ)
  - FSM state enum
  - NUM_BANK=4 and the bank-index typedef
- Sub-module gpio_pin_sync handles one bank: SYNC_STG synchronizer, prev flop, rise output. It is instantiated 4 times.

Test Plan:
- Pins b2=4'hA driven high through reset, release -> status stays 0, irq_o=0 for 20 cycles.
- WR_DIR bank1 data 4'hF at T, TURN_CYC=2 -> b1_data_io Z through T+2, driven from T+3, rsp_valid_o at T+3.
- WR_OUT bank1 4'h5 after dir=F -> b1_data_io=4'h5 from T+1; RD_IN bank1 after SYNC_STG cycles -> rsp_data_o=4'h5.
- Bank0 input, TB drives b0 0->4'h3 -> status[0]=3 after SYNC_STG+1 cycles, irq_o=1 one cycle later. CLR_IRQ 4'h1 -> rsp_data_o=3, status=2, irq_o stays 1.
- CLR_IRQ bit0 in the same cycle bit0 sees a new rise -> status bit0 remains 1.
- rst_n_i low during TURN of WR_DIR bank3 -> no rsp_valid_o, b3_data_io Z, cmd_ready_o=1 the cycle after reset release.
